regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 32×32 architectural register file in the decode stage. Two producers compete for the register file's single write port: the ALU result path and the load-return path. This block arbitrates between them, registers the winner onto the write port, and keeps a per-register pending-write scoreboard. Decode uses the scoreboard output to stall on RAW hazards.

---
 rtl/regfile_wb_scheduler.sv | 117 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates ALU/load results onto the register-file write port
// and keeps a per-register pending-write scoreboard. Optional macro: WB_ARB_ROUND_ROBIN_EN.
module regfile_wb_scheduler #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [4:0]  alu_wb_addr,
  input  logic [31:0] alu_wb_data,
  input  logic        mem_wb_valid,
  output logic        mem_wb_ready,
  input  logic [4:0]  mem_wb_addr,
  input  logic [31:0] mem_wb_data,
  output logic        regfile_wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard_stall
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic mem_wins;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic alu_last_q;  // 1: ALU won the most recent conflict

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_last_q <= 1'b1;
    end else if (alu_wb_valid && mem_wb_valid) begin
      alu_last_q <= alu_wb_ready;
    end
  end

  assign mem_wins = alu_last_q;
`else
  assign mem_wins = 1'b1;
`endif

  assign mem_wb_ready = mem_wb_valid && (!alu_wb_valid || mem_wins);
  assign alu_wb_ready = alu_wb_valid && !mem_wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regfile_wr_en <= 1'b0;
      wr_addr       <= 5'd0;
      wr_data       <= 32'd0;
    end else begin
      regfile_wr_en <= (mem_wb_ready && (mem_wb_addr != 5'd0)) ||
                       (alu_wb_ready && (alu_wb_addr != 5'd0));
      if (mem_wb_ready) begin
        wr_addr <= mem_wb_addr;
        wr_data <= mem_wb_data;
      end else if (alu_wb_ready) begin
        wr_addr <= alu_wb_addr;
        wr_data <= alu_wb_data;
      end
    end
  end

  logic [CNT_W-1:0] cnt_q    [1:31];
  logic [CNT_W-1:0] cnt_view [32];
  logic [31:0]      inc_vec;
  logic [31:0]      dec_vec;
  logic             issue_fire;

  always_comb begin
    cnt_view[0] = CNT_ZERO;
    for (int r = 1; r < 32; r++) begin
      cnt_view[r] = cnt_q[r];
    end
  end

  always_comb begin
    dec_vec = '0;
    if (regfile_wr_en) begin
      dec_vec[wr_addr] = 1'b1;
    end
  end

  // A saturated counter can still accept an issue when the same register retires this cycle.
  assign issue_ready = !((issue_rd != 5'd0) && (cnt_view[issue_rd] == CNT_MAX) &&
                         !dec_vec[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

  always_comb begin
    inc_vec = '0;
    if (issue_fire) begin
      inc_vec[issue_rd] = 1'b1;
    end
  end

  for (genvar r = 1; r < 32; r++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[r] <= CNT_ZERO;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_q[r] <= cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != CNT_ZERO)) begin
        cnt_q[r] <= cnt_q[r] - CNT_ONE;
      end
    end
  end

  assign hazard_stall = ((rs1_addr != 5'd0) && (cnt_view[rs1_addr] != CNT_ZERO)) ||
                        ((rs2_addr != 5'd0) && (cnt_view[rs2_addr] != CNT_ZERO));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler against a cycle-level model of the
// write port, arbitration turn and per-register pending-write counts.
module tb_regfile_wb_scheduler;

  localparam int CNT_W = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [4:0]  mem_wb_addr;
  logic [31:0] mem_wb_data;
  logic        regfile_wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr;
  logic        hazard_stall;

  regfile_wb_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .regfile_wr_en(regfile_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending count per register and the write port of the current cycle.
  int          m_cnt [32];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_mem_turn;
  int          owed  [32];

  function automatic bit exp_mem_grant();
    if (!mem_wb_valid) return 1'b0;
    if (!alu_wb_valid) return 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    return m_mem_turn;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_alu_grant();
    return alu_wb_valid && !exp_mem_grant();
  endfunction

  function automatic bit exp_issue_ok();
    if (issue_rd == 5'd0) return 1'b1;
    return (m_cnt[issue_rd] < MAX) || (m_en && (m_addr == issue_rd));
  endfunction

  function automatic bit exp_hazard();
    return ((rs1_addr != 5'd0) && (m_cnt[rs1_addr] != 0)) ||
           ((rs2_addr != 5'd0) && (m_cnt[rs2_addr] != 0));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      owed[r]  = 0;
    end
    m_en       = 1'b0;
    m_addr     = 5'd0;
    m_data     = 32'd0;
    m_mem_turn = 1'b1;
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 1'b0; alu_wb_addr = 5'd0; alu_wb_data = 32'd0;
    mem_wb_valid = 1'b0; mem_wb_addr = 5'd0; mem_wb_data = 32'd0;
    issue_valid  = 1'b0; issue_rd    = 5'd0;
    rs1_addr     = 5'd0; rs2_addr    = 5'd0;
  endtask

  // Advance one clock and move the model to the post-edge state.
  task automatic tick();
    bit gm, ga, acc;
    logic [4:0] ird;
    gm  = exp_mem_grant();
    ga  = exp_alu_grant();
    acc = issue_valid && (issue_rd != 5'd0) && exp_issue_ok();
    ird = issue_rd;
    assert (!(regfile_wr_en && (m_cnt[wr_addr] == 0)))
      else $error("protocol: write-back to x%0d with no pending issue", wr_addr);
    @(posedge clk);
    if (m_en && (m_cnt[m_addr] > 0)) m_cnt[m_addr]--;
    if (acc) m_cnt[ird]++;
    if (alu_wb_valid && mem_wb_valid) m_mem_turn = ga;
    m_en = (gm && (mem_wb_addr != 5'd0)) || (ga && (alu_wb_addr != 5'd0));
    if (gm) begin
      m_addr = mem_wb_addr; m_data = mem_wb_data;
    end else if (ga) begin
      m_addr = alu_wb_addr; m_data = alu_wb_data;
    end
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_n(input logic [4:0] rd, input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid = 1'b1; issue_rd = rd;
      tick();
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd3;
    issue_rd = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd9;
    #1;
    n_vec++;
    if ({regfile_wr_en, wr_addr, wr_data} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_port: got en=%b addr=%0d data=%h, need all zero", regfile_wr_en, wr_addr, wr_data);
    end
    n_vec++;
    if ({alu_wb_ready, mem_wb_ready, issue_ready, hazard_stall} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_comb: got alu_rdy/mem_rdy/iss_rdy/stall=%b%b%b%b, need 1010",
               alu_wb_ready, mem_wb_ready, issue_ready, hazard_stall);
    end
    apply_reset();
  endtask

  task automatic test_lone_alu();
    issue_n(5'd5, 1);
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
    #1;
    n_vec++;
    if ({alu_wb_ready, mem_wb_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL lone_alu_ready: got alu=%b mem=%b, need alu=1 mem=0", alu_wb_ready, mem_wb_ready);
    end
    tick();
    alu_wb_valid = 1'b0;
    n_vec++;
    if ({regfile_wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL lone_alu_port: got en=%b addr=%0d data=%h, need 1/5/deadbeef", regfile_wr_en, wr_addr, wr_data);
    end
    tick();
    apply_reset();
  endtask

  task automatic test_conflict();
    bit em;
    issue_n(5'd1, 2);
    issue_n(5'd2, 2);
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd1; alu_wb_data = 32'h0000_00A1;
    mem_wb_valid = 1'b1; mem_wb_addr = 5'd2; mem_wb_data = 32'h0000_00B2;
    issue_valid  = 1'b1; issue_rd    = 5'd2;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      em = ((i % 2) == 0);
`else
      em = 1'b1;
`endif
      #1;
      n_vec++;
      if ({mem_wb_ready, alu_wb_ready} !== {em, !em}) begin
        n_err++;
        $display("FAIL conflict_grant[%0d]: got mem=%b alu=%b, need mem=%b alu=%b",
                 i, mem_wb_ready, alu_wb_ready, em, !em);
      end
      tick();
      n_vec++;
      if ({regfile_wr_en, wr_addr, wr_data} !== (em ? {1'b1, 5'd2, 32'hB2} : {1'b1, 5'd1, 32'hA1})) begin
        n_err++;
        $display("FAIL conflict_port[%0d]: got en=%b addr=%0d data=%h", i, regfile_wr_en, wr_addr, wr_data);
      end
    end
    idle_inputs();
    tick();
    apply_reset();
  endtask

  task automatic test_x0();
    mem_wb_valid = 1'b1; mem_wb_addr = 5'd0; mem_wb_data = 32'h0000_1234;
    #1;
    n_vec++;
    if (mem_wb_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_ready: got %b need 1", mem_wb_ready);
    end
    tick();
    mem_wb_valid = 1'b0;
    #1;
    n_vec++;
    if ({regfile_wr_en, wr_addr, wr_data} !== {1'b0, 5'd0, 32'h1234}) begin
      n_err++;
      $display("FAIL x0_port: got en=%b addr=%0d data=%h, need 0/0/00001234", regfile_wr_en, wr_addr, wr_data);
    end
    for (int r = 0; r < 32; r++) begin
      rs1_addr = r[4:0];
      #1;
      n_vec++;
      if (hazard_stall !== 1'b0) begin
        n_err++;
        $display("FAIL x0_counters[%0d]: stall got %b need 0", r, hazard_stall);
      end
    end
    apply_reset();
  endtask

  task automatic test_scoreboard();
    issue_n(5'd7, 1);
    rs1_addr = 5'd7;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL sb_pending: stall got %b need 1", hazard_stall);
    end
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd7; alu_wb_data = 32'h77;
    tick();
    alu_wb_valid = 1'b0;
    n_vec++;
    if ({hazard_stall, regfile_wr_en, wr_addr} !== {1'b1, 1'b1, 5'd7}) begin
      n_err++;
      $display("FAIL sb_n1: got stall=%b en=%b addr=%0d, need 1/1/7", hazard_stall, regfile_wr_en, wr_addr);
    end
    tick();
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL sb_n2: stall got %b need 0", hazard_stall);
    end
    apply_reset();
  endtask

  task automatic test_saturation();
    issue_n(5'd9, 3);
    issue_valid = 1'b1; issue_rd = 5'd9; rs2_addr = 5'd9;
    #1;
    n_vec++;
    if ({issue_ready, hazard_stall} !== 2'b01) begin
      n_err++;
      $display("FAIL sat_full: got iss_rdy=%b stall=%b, need 0/1", issue_ready, hazard_stall);
    end
    issue_rd = 5'd0;
    #1;
    n_vec++;
    if (issue_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sat_x0: iss_rdy got %b need 1", issue_ready);
    end
    issue_valid = 1'b0; issue_rd = 5'd9;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd9; alu_wb_data = 32'h99;
    tick();
    alu_wb_valid = 1'b0;
    issue_valid = 1'b1;
    #1;
    n_vec++;
    if ({regfile_wr_en, issue_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL sat_retire_issue: got en=%b iss_rdy=%b, need 1/1", regfile_wr_en, issue_ready);
    end
    tick();
    n_vec++;
    if ({regfile_wr_en, issue_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL sat_still_full: got en=%b iss_rdy=%b, need 0/0", regfile_wr_en, issue_ready);
    end
    issue_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_async_reset();
    issue_n(5'd3, 2);
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 32'h3333;
    mem_wb_valid = 1'b1; mem_wb_addr = 5'd4; mem_wb_data = 32'h4444;
    tick();
    rs1_addr = 5'd3;
    #1;
    n_vec++;
    if ({regfile_wr_en, hazard_stall} !== 2'b11) begin
      n_err++;
      $display("FAIL arst_pre: got en=%b stall=%b, need 1/1", regfile_wr_en, hazard_stall);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({regfile_wr_en, hazard_stall, issue_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL arst_now: got en=%b stall=%b iss_rdy=%b, need 0/0/1", regfile_wr_en, hazard_stall, issue_ready);
    end
    idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_vec++;
    if ({wr_addr, wr_data} !== 37'd0) begin
      n_err++;
      $display("FAIL arst_port: got addr=%0d data=%h, need 0/0", wr_addr, wr_data);
    end
    for (int r = 1; r < 32; r++) begin
      rs2_addr = r[4:0];
      #0.1;
      n_vec++;
      if (hazard_stall !== 1'b0) begin
        n_err++;
        $display("FAIL arst_counter[%0d]: stall got %b need 0", r, hazard_stall);
      end
    end
    rs2_addr = 5'd0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] cand[$];
    int k;
    for (int r = 1; r < 32; r++) if (owed[r] > 0) cand.push_back(r[4:0]);
    if ((cand.size() == 0) || ($urandom_range(0, 7) == 0)) return 5'd0;
    k = $urandom_range(0, cand.size() - 1);
    owed[cand[k]]--;
    return cand[k];
  endfunction

  task automatic test_back_to_back();
    bit ga, gm, acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!alu_wb_valid && ($urandom_range(0, 3) != 0)) begin
        alu_wb_valid = 1'b1; alu_wb_addr = pick_reg(); alu_wb_data = $urandom;
      end
      if (!mem_wb_valid && ($urandom_range(0, 3) != 0)) begin
        mem_wb_valid = 1'b1; mem_wb_addr = pick_reg(); mem_wb_data = $urandom;
      end
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 9));
      rs2_addr    = 5'($urandom_range(0, 9));
      #1;
      ga  = exp_alu_grant();
      gm  = exp_mem_grant();
      acc = issue_valid && (issue_rd != 5'd0) && exp_issue_ok();
      n_vec++;
      if ({alu_wb_ready, mem_wb_ready, issue_ready, hazard_stall} !==
          {ga, gm, exp_issue_ok(), exp_hazard()}) begin
        n_err++;
        $display("FAIL rand_comb[%0d]: got alu/mem/iss/stall=%b%b%b%b, need %b%b%b%b", cyc,
                 alu_wb_ready, mem_wb_ready, issue_ready, hazard_stall,
                 ga, gm, exp_issue_ok(), exp_hazard());
      end
      if (acc) owed[issue_rd]++;
      tick();
      n_vec++;
      if ({regfile_wr_en, wr_addr, wr_data} !== {m_en, m_addr, m_data}) begin
        n_err++;
        $display("FAIL rand_port[%0d]: got en=%b addr=%0d data=%h, need en=%b addr=%0d data=%h", cyc,
                 regfile_wr_en, wr_addr, wr_data, m_en, m_addr, m_data);
      end
      if (ga) alu_wb_valid = 1'b0;
      if (gm) mem_wb_valid = 1'b0;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    #1;
    test_reset();
    test_lone_alu();
    test_conflict();
    test_x0();
    test_scoreboard();
    test_saturation();
    apply_reset();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
